// File: rtl/fdc_disk_responder_if.sv
// Signal bundle between the disk responder, the nec765 FDC core and the backing image store.
// The master side is the responder; the slave side is the FDC plus memory bridge.
interface fdc_disk_responder_if #(
  parameter int ADDR_W = 20
);
  logic [31:0]       disk_sr;
  logic [31:0]       disk_cr;
  logic [7:0]        disk_data_in;
  logic              disk_data_clkin;
  logic [7:0]        disk_data_out;
  logic              disk_data_clkout;
  logic [1:0]        img_present;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport master (
    input  disk_sr, disk_data_out, img_present, mem_rdata, mem_ack,
    output disk_cr, disk_data_in, disk_data_clkin, disk_data_clkout,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    output disk_sr, disk_data_out, img_present, mem_rdata, mem_ack,
    input  disk_cr, disk_data_in, disk_data_clkin, disk_data_clkout,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/fdc_disk_responder.sv
// Disk-side responder for the nec765 FDC emulation: seek / sector read / sector write / next-ID.
// Define FDC_RESP_TIMEOUT_EN to add a mem_ack watchdog that aborts a stalled transfer with error.
module fdc_disk_responder #(
  parameter int                TRACKS      = 40,
  parameter int                SIDES       = 1,
  parameter int                SECTORS     = 9,
  parameter logic [7:0]        SECTOR_BASE = 8'hC1,
  parameter int                ADDR_W      = 20,
  parameter logic [ADDR_W-1:0] DRIVE1_BASE = 20'h40000,
  parameter int                TIMEOUT     = 4095
) (
  input logic                  clk,
  input logic                  rst_n,
  fdc_disk_responder_if.master bus
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] CALC1    = 4'd1;
  localparam logic [3:0] CALC2    = 4'd2;
  localparam logic [3:0] RD_REQ   = 4'd3;
  localparam logic [3:0] RD_WAIT  = 4'd4;
  localparam logic [3:0] RD_PUSH  = 4'd5;
  localparam logic [3:0] WR_POP   = 4'd6;
  localparam logic [3:0] WR_REQ   = 4'd7;
  localparam logic [3:0] WR_WAIT  = 4'd8;
  localparam logic [3:0] DONE     = 4'd9;
`ifdef FDC_RESP_TIMEOUT_EN
  localparam logic [3:0] WR_DRAIN = 4'd10;
`endif

  localparam logic [7:0] LAST_ID = SECTOR_BASE + 8'(SECTORS - 1);

  logic [3:0]        state;
  logic [6:0]        cyl;
  logic              head;
  logic [7:0]        sector;
  logic              drive_sel;
  logic              op_seek;
  logic              op_read;
  logic              valid_q;
  logic [31:0]       lba_q;
  logic [9:0]        byte_cnt;
  logic [7:0]        id_cnt;
  logic [7:0]        cr_id;
  logic              nid_q;
  logic              nid_prev;
  logic              cr_present;
  logic              cr_done;
  logic              cr_err;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [7:0]        mem_wdata_q;
  logic [7:0]        data_in_q;
  logic              clkin_q;
  logic              clkout_q;

  logic [31:0]       sr;
  logic              req_any;
  logic              sector_ok;
  logic              valid_calc;
  logic [31:0]       lba_calc;
  logic [ADDR_W-1:0] drive_base;
  logic [ADDR_W-1:0] addr_calc;
  logic              unused_sr;

  assign sr        = bus.disk_sr;
  assign req_any   = |{sr[25:24], sr[21:20], sr[18:17]};
  assign unused_sr = ^{sr[31:26], sr[23], sr[19], sr[16]};

  assign sector_ok  = (sector >= SECTOR_BASE) &&
                      ({1'b0, sector} < ({1'b0, SECTOR_BASE} + 9'(SECTORS)));
  assign valid_calc = bus.img_present[drive_sel] && (32'(cyl) < 32'(TRACKS)) &&
                      (32'(head) < 32'(SIDES)) && (op_seek || sector_ok);
  assign lba_calc   = (32'(cyl) * 32'(SIDES) + 32'(head)) * 32'(SECTORS) +
                      32'(sector) - 32'(SECTOR_BASE);
  assign drive_base = drive_sel ? DRIVE1_BASE : '0;
  assign addr_calc  = drive_base + ADDR_W'(lba_q << 9);

`ifdef FDC_RESP_TIMEOUT_EN
  logic [11:0] wd_cnt;
  logic        wd_expired;

  assign wd_expired = (wd_cnt == 12'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n || !(mem_rd_q || mem_wr_q))
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 12'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  // Next-ID tracking runs independently of the transfer FSM so the FDC can step IDs at any time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nid_q      <= 1'b0;
      nid_prev   <= 1'b0;
      id_cnt     <= SECTOR_BASE;
      cr_id      <= 8'd0;
      cr_present <= 1'b0;
    end else begin
      nid_q      <= sr[22];
      nid_prev   <= nid_q;
      if (nid_q != nid_prev)
        id_cnt <= (id_cnt == LAST_ID) ? SECTOR_BASE : id_cnt + 8'd1;
      cr_id      <= id_cnt;
      cr_present <= bus.img_present[drive_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      drive_sel   <= 1'b0;
      cyl         <= 7'd0;
      head        <= 1'b0;
      sector      <= 8'd0;
      op_seek     <= 1'b0;
      op_read     <= 1'b0;
      valid_q     <= 1'b0;
      lba_q       <= 32'd0;
      byte_cnt    <= 10'd0;
      cr_done     <= 1'b0;
      cr_err      <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= 8'd0;
      data_in_q   <= 8'd0;
      clkin_q     <= 1'b0;
      clkout_q    <= 1'b0;
    end else begin
      clkin_q  <= 1'b0;
      clkout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            cyl    <= sr[14:8];
            head   <= sr[15];
            sector <= sr[7:0];
            if (sr[24] || sr[25]) begin
              op_seek   <= 1'b1;
              op_read   <= 1'b0;
              drive_sel <= !sr[24];
            end else if (sr[17] || sr[18]) begin
              op_seek   <= 1'b0;
              op_read   <= 1'b1;
              drive_sel <= !sr[17];
            end else begin
              op_seek   <= 1'b0;
              op_read   <= 1'b0;
              drive_sel <= !sr[20];
            end
            state <= CALC1;
          end
        end
        CALC1: begin
          valid_q <= valid_calc;
          lba_q   <= lba_calc;
          state   <= CALC2;
        end
        CALC2: begin
          if (!valid_q || op_seek) begin
            cr_done <= 1'b1;
            cr_err  <= !valid_q;
            state   <= DONE;
          end else begin
            mem_addr_q <= addr_calc;
            byte_cnt   <= 10'd0;
            if (op_read) begin
              state <= RD_REQ;
            end else begin
              clkout_q <= 1'b1;
              state    <= WR_POP;
            end
          end
        end
        RD_REQ: begin
          mem_rd_q <= 1'b1;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (bus.mem_ack) begin
            mem_rd_q  <= 1'b0;
            data_in_q <= bus.mem_rdata;
            clkin_q   <= 1'b1;
            state     <= RD_PUSH;
          end
`ifdef FDC_RESP_TIMEOUT_EN
          else if (wd_expired) begin
            mem_rd_q <= 1'b0;
            cr_done  <= 1'b1;
            cr_err   <= 1'b1;
            state    <= DONE;
          end
`endif
        end
        RD_PUSH: begin
          mem_addr_q <= mem_addr_q + 1'b1;
          byte_cnt   <= byte_cnt + 10'd1;
          if (byte_cnt == 10'd511) begin
            cr_done <= 1'b1;
            cr_err  <= 1'b0;
            state   <= DONE;
          end else begin
            state <= RD_REQ;
          end
        end
        // The FIFO head is sampled in the same cycle its pop strobe is high.
        WR_POP: begin
          mem_wdata_q <= bus.disk_data_out;
          state       <= WR_REQ;
        end
        WR_REQ: begin
          mem_wr_q <= 1'b1;
          state    <= WR_WAIT;
        end
        WR_WAIT: begin
          if (bus.mem_ack) begin
            mem_wr_q   <= 1'b0;
            mem_addr_q <= mem_addr_q + 1'b1;
            byte_cnt   <= byte_cnt + 10'd1;
            if (byte_cnt == 10'd511) begin
              cr_done <= 1'b1;
              cr_err  <= 1'b0;
              state   <= DONE;
            end else begin
              clkout_q <= 1'b1;
              state    <= WR_POP;
            end
          end
`ifdef FDC_RESP_TIMEOUT_EN
          else if (wd_expired) begin
            mem_wr_q <= 1'b0;
            if (byte_cnt == 10'd511) begin
              cr_done <= 1'b1;
              cr_err  <= 1'b1;
              state   <= DONE;
            end else begin
              byte_cnt <= byte_cnt + 10'd1;
              clkout_q <= 1'b1;
              state    <= WR_DRAIN;
            end
          end
`endif
        end
`ifdef FDC_RESP_TIMEOUT_EN
        // Empty the rest of the FDC output FIFO so the next command starts clean.
        WR_DRAIN: begin
          if (byte_cnt == 10'd511) begin
            cr_done <= 1'b1;
            cr_err  <= 1'b1;
            state   <= DONE;
          end else begin
            byte_cnt <= byte_cnt + 10'd1;
            clkout_q <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (!req_any) begin
            cr_done <= 1'b0;
            cr_err  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.disk_cr          = {cr_id, 18'd0, cr_present, cr_done, cr_err, 3'd0};
  assign bus.disk_data_in     = data_in_q;
  assign bus.disk_data_clkin  = clkin_q;
  assign bus.disk_data_clkout = clkout_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_rd           = mem_rd_q;
  assign bus.mem_wr           = mem_wr_q;
  assign bus.mem_wdata        = mem_wdata_q;

endmodule

// File: tb/tb_fdc_disk_responder.sv
// Scoreboard bench for fdc_disk_responder: memory responder model, FDC FIFO model, strobe monitors.
module tb_fdc_disk_responder;
  localparam int ADDR_W  = 20;
  localparam int TIMEOUT = 4095;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fdc_disk_responder_if #(.ADDR_W(ADDR_W)) bus ();

  fdc_disk_responder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int clkin_cnt = 0;
  int clkout_cnt = 0;
  int access_cycles = 0;
  bit ack_enable = 1'b1;
  bit nid_level = 1'b0;

  logic [7:0]        exp_byte_q[$];
  logic [ADDR_W-1:0] exp_rd_addr_q[$];
  logic [ADDR_W-1:0] exp_wr_addr_q[$];
  logic [7:0]        exp_wr_data_q[$];
  logic [7:0]        fifo_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h5A;
  endfunction

  // Reference address: ((cyl*SIDES + head)*SECTORS + (id - base))*512 + drive offset.
  function automatic logic [ADDR_W-1:0] sector_addr(input bit drv, input int cyl, input int hd,
                                                     input int id);
    int lba;
    lba = (cyl * 1 + hd) * 9 + (id - 'hC1);
    return ADDR_W'(lba * 512 + (drv ? 'h40000 : 0));
  endfunction

  function automatic logic [31:0] req(input int bit_idx, input int cyl, input logic hd,
                                      input logic [7:0] id);
    logic [31:0] w;
    w        = 32'd1 << bit_idx;
    w[14:8]  = 7'(cyl);
    w[15]    = hd;
    w[7:0]   = id;
    return w;
  endfunction

  task automatic applyStimulus(input logic [31:0] sr, input logic [1:0] present);
    @(negedge clk);
    bus.disk_sr     = (sr & ~32'h0040_0000) | (32'(nid_level) << 22);
    bus.img_present = present;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (bus.disk_cr[4] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 32'(bus.disk_cr[4]), 32'd1);
  endtask

  task automatic clearReq(input string tag, input logic [1:0] present);
    applyStimulus(32'd0, present);
    @(negedge clk);
    checkOutput({tag, "_done_clr"}, 32'(bus.disk_cr[4]), 32'd0);
    checkOutput({tag, "_err_clr"}, 32'(bus.disk_cr[3]), 32'd0);
  endtask

  // Memory bridge model: acks after a few cycles and checks each access against the scoreboard.
  initial begin
    int lat;
    lat = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        lat = 0;
      end else if (rst_n && ack_enable && (bus.mem_rd || bus.mem_wr)) begin
        if (lat < 2) begin
          lat++;
        end else begin
          lat = 0;
          bus.mem_ack = 1'b1;
          if (bus.mem_rd) begin
            bus.mem_rdata = mem_byte(bus.mem_addr);
            if (exp_rd_addr_q.size() == 0) checkOutput("rd_unexpected", 32'd1, 32'd0);
            else checkOutput("rd_addr", 32'(bus.mem_addr), 32'(exp_rd_addr_q.pop_front()));
          end else begin
            if (exp_wr_addr_q.size() == 0) begin
              checkOutput("wr_unexpected", 32'd1, 32'd0);
            end else begin
              checkOutput("wr_addr", 32'(bus.mem_addr), 32'(exp_wr_addr_q.pop_front()));
              checkOutput("wr_data", 32'(bus.mem_wdata), 32'(exp_wr_data_q.pop_front()));
            end
          end
        end
      end else begin
        lat = 0;
      end
    end
  end

  // FDC output FIFO model: show-ahead head, popped just after the strobed edge.
  initial begin
    bus.disk_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.disk_data_clkout) begin
        clkout_cnt++;
        checkOutput("fifo_pop_nonempty", 32'(fifo_q.size() > 0), 32'd1);
        @(posedge clk);
        #1;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      bus.disk_data_out = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.disk_data_clkin) begin
        clkin_cnt++;
        if (exp_byte_q.size() == 0) checkOutput("clkin_unexpected", 32'd1, 32'd0);
        else checkOutput("clkin_byte", 32'(bus.disk_data_in), 32'(exp_byte_q.pop_front()));
      end
      if (bus.mem_rd || bus.mem_wr) access_cycles++;
    end
  end

  task automatic runRead(input logic [7:0] id, input int cyl, input bit remove_mid);
    logic [ADDR_W-1:0] base;
    int start;
    base = sector_addr(1'b0, cyl, 0, int'(id));
    for (int i = 0; i < 512; i++) begin
      exp_rd_addr_q.push_back(base + ADDR_W'(i));
      exp_byte_q.push_back(mem_byte(base + ADDR_W'(i)));
    end
    start = clkin_cnt;
    applyStimulus(req(17, cyl, 1'b0, id), 2'b01);
    if (remove_mid) begin
      for (int n = 0; n < 5000 && clkin_cnt < start + 50; n++) @(negedge clk);
      bus.img_present = 2'b00;
    end
    waitDone(20000);
    checkOutput("rd_strobes", 32'(clkin_cnt - start), 32'd512);
    checkOutput("rd_err", 32'(bus.disk_cr[3]), 32'd0);
    checkOutput("rd_present", 32'(bus.disk_cr[5]), remove_mid ? 32'd0 : 32'd1);
    checkOutput("rd_bytes_left", 32'(exp_byte_q.size()), 32'd0);
    checkOutput("rd_addrs_left", 32'(exp_rd_addr_q.size()), 32'd0);
    clearReq("rd", remove_mid ? 2'b00 : 2'b01);
  endtask

  logic [7:0] bad_id[3] = '{8'hC0, 8'hCA, 8'hC1};
  logic [1:0] bad_pr[3] = '{2'b01, 2'b01, 2'b00};

  initial begin
    int start;
    int acc;
    bus.disk_sr     = 32'd0;
    bus.img_present = 2'b01;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cr", bus.disk_cr, 32'd0);
    checkOutput("rst_clkin", 32'(bus.disk_data_clkin), 32'd0);
    checkOutput("rst_clkout", 32'(bus.disk_data_clkout), 32'd0);
    checkOutput("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    checkOutput("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_id", 32'(bus.disk_cr[31:24]), 32'hC1);
    checkOutput("idle_present", 32'(bus.disk_cr[5]), 32'd1);
    checkOutput("idle_done", 32'(bus.disk_cr[4]), 32'd0);

    for (int k = 1; k <= 9; k++) begin
      nid_level = ~nid_level;
      applyStimulus(32'd0, 2'b01);
      repeat (4) @(negedge clk);
      checkOutput("next_id", 32'(bus.disk_cr[31:24]), 32'hC1 + 32'(k % 9));
    end

    runRead(8'hC3, 2, 1'b0);
    runRead(8'hC2, 2, 1'b1);

    fifo_q.delete();
    for (int i = 0; i < 512; i++) begin
      fifo_q.push_back(8'(i));
      exp_wr_addr_q.push_back(ADDR_W'('h40000 + i));
      exp_wr_data_q.push_back(8'(i));
    end
    start = clkout_cnt;
    applyStimulus(req(21, 0, 1'b0, 8'hC1), 2'b11);
    waitDone(20000);
    checkOutput("wr_strobes", 32'(clkout_cnt - start), 32'd512);
    checkOutput("wr_err", 32'(bus.disk_cr[3]), 32'd0);
    checkOutput("wr_fifo_left", 32'(fifo_q.size()), 32'd0);
    checkOutput("wr_left", 32'(exp_wr_addr_q.size()), 32'd0);
    clearReq("wr", 2'b01);

    acc = access_cycles;
    applyStimulus(req(24, 40, 1'b0, 8'hC1), 2'b01);
    waitDone(50);
    checkOutput("seek40_err", 32'(bus.disk_cr[3]), 32'd1);
    checkOutput("seek40_no_mem", 32'(access_cycles - acc), 32'd0);
    clearReq("seek40", 2'b01);
    applyStimulus(req(24, 39, 1'b0, 8'hC1), 2'b01);
    waitDone(50);
    checkOutput("seek39_err", 32'(bus.disk_cr[3]), 32'd0);
    checkOutput("seek39_no_mem", 32'(access_cycles - acc), 32'd0);
    clearReq("seek39", 2'b01);

    for (int c = 0; c < 3; c++) begin
      start = clkin_cnt;
      applyStimulus(req(17, 0, 1'b0, bad_id[c]), bad_pr[c]);
      waitDone(50);
      checkOutput("bad_err", 32'(bus.disk_cr[3]), 32'd1);
      checkOutput("bad_present", 32'(bus.disk_cr[5]), 32'(bad_pr[c][0]));
      checkOutput("bad_no_clkin", 32'(clkin_cnt - start), 32'd0);
      clearReq("bad", 2'b01);
    end

    for (int i = 0; i < 512; i++) begin
      exp_rd_addr_q.push_back(ADDR_W'(i));
      exp_byte_q.push_back(mem_byte(ADDR_W'(i)));
    end
    start = clkin_cnt;
    applyStimulus(req(17, 0, 1'b0, 8'hC1), 2'b01);
    for (int n = 0; n < 5000 && clkin_cnt < start + 100; n++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_cr", bus.disk_cr, 32'd0);
    checkOutput("abort_clkin", 32'(bus.disk_data_clkin), 32'd0);
    checkOutput("abort_mem_rd", 32'(bus.mem_rd), 32'd0);
    checkOutput("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
    start = clkin_cnt;
    repeat (3) @(negedge clk);
    exp_byte_q.delete();
    exp_rd_addr_q.delete();
    applyStimulus(32'd0, 2'b01);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("abort_no_strobes", 32'(clkin_cnt - start), 32'd0);
    checkOutput("abort_idle_rd", 32'(bus.mem_rd), 32'd0);

`ifdef FDC_RESP_TIMEOUT_EN
    ack_enable = 1'b0;
    start = clkin_cnt;
    applyStimulus(req(17, 0, 1'b0, 8'hC1), 2'b01);
    waitDone(TIMEOUT + 200);
    checkOutput("to_rd_err", 32'(bus.disk_cr[3]), 32'd1);
    checkOutput("to_rd_no_clkin", 32'(clkin_cnt - start), 32'd0);
    clearReq("to_rd", 2'b01);
    fifo_q.delete();
    for (int i = 0; i < 512; i++) fifo_q.push_back(8'(i));
    start = clkout_cnt;
    applyStimulus(req(20, 0, 1'b0, 8'hC1), 2'b01);
    waitDone(TIMEOUT + 1000);
    checkOutput("to_wr_err", 32'(bus.disk_cr[3]), 32'd1);
    checkOutput("to_wr_pops", 32'(clkout_cnt - start), 32'd512);
    checkOutput("to_wr_fifo_left", 32'(fifo_q.size()), 32'd0);
    clearReq("to_wr", 2'b01);
    ack_enable = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL sim_watchdog: got expired, expected finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

endmodule
